// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_ctrl_pkg;

  localparam int unsigned NB_DMEM_ADDR = 10;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } dmem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: enables, store-data shift, load-data
// right-justify/mask and misalignment detection for a 32-bit word.
module dmem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [3:0]  be_base;
  logic [31:0] dmask;
  logic [4:0]  shamt;

  always_comb begin
    be_base    = 4'b1111;
    dmask      = '1;
    misalign_o = (addr_lo_i != 2'b00);
    case (size_i)
      SZ_BYTE: begin
        be_base    = 4'b0001;
        dmask      = 32'h0000_00FF;
        misalign_o = 1'b0;
      end
      SZ_HALF: begin
        be_base    = 4'b0011;
        dmask      = 32'h0000_FFFF;
        misalign_o = addr_lo_i[0];
      end
      default: ; // 2'b10 and 2'b11 both behave as a word access
    endcase
    shamt   = {addr_lo_i, 3'b000};
    be_o    = be_base << addr_lo_i;
    wdata_o = wdata_i << shamt;
    rdata_o = (mem_rdata_i >> shamt) & dmask;
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller in front of a word-wide synchronous SRAM.
// Optional statistics counters are built when DMEM_STATS_EN is defined.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned NB_ADDR     = 32,
  parameter int unsigned NB_WORD     = 32,
  parameter int unsigned NB_MEM_ADDR = NB_DMEM_ADDR,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_req_valid,
  input  logic                   i_req_wr,
  input  logic [NB_ADDR-1:0]     i_req_addr,
  input  logic [NB_WORD-1:0]     i_req_wdata,
  input  logic [1:0]             i_req_size,
  output logic                   o_req_ready,
  output logic                   o_rsp_valid,
  output logic [NB_WORD-1:0]     o_rsp_rdata,
  output logic                   o_rsp_err,
  output logic                   o_mem_cs,
  output logic                   o_mem_we,
  output logic [3:0]             o_mem_be,
  output logic [NB_MEM_ADDR-1:0] o_mem_addr,
  output logic [NB_WORD-1:0]     o_mem_wdata,
  input  logic [NB_WORD-1:0]     i_mem_rdata,
  output logic [31:0]            o_stat_rd_cnt,
  output logic [31:0]            o_stat_wr_cnt,
  output logic [31:0]            o_stat_stall_cnt
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  dmem_state_t              state_q, state_d;
  logic                     wr_q, wr_d;
  logic [NB_MEM_ADDR+1:0]   addr_q, addr_d;
  logic [NB_WORD-1:0]       wdata_q, wdata_d;
  logic [1:0]               size_q, size_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [NB_WORD-1:0]       rdata_q, rdata_d;
  logic                     err_q, err_d;

  logic [1:0]   al_size;
  logic [1:0]   al_addr;
  logic [3:0]   al_be;
  logic [31:0]  al_wdata;
  logic [31:0]  al_rdata;
  logic         al_misalign;
  logic         unused_addr_hi;

  // Bits above the SRAM word address wrap around and are never stored.
  assign unused_addr_hi = ^i_req_addr[NB_ADDR-1:NB_MEM_ADDR+2];

  // In IDLE the lane logic sees the live request so misalignment is
  // known in the accept cycle; afterwards it sees the latched request.
  assign al_size = (state_q == IDLE) ? i_req_size      : size_q;
  assign al_addr = (state_q == IDLE) ? i_req_addr[1:0] : addr_q[1:0];

  dmem_lane_align u_lane_align (
    .size_i      (al_size),
    .addr_lo_i   (al_addr),
    .wdata_i     (wdata_q),
    .mem_rdata_i (i_mem_rdata),
    .be_o        (al_be),
    .wdata_o     (al_wdata),
    .rdata_o     (al_rdata),
    .misalign_o  (al_misalign)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_mem_cs    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_be    = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    case (state_q)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          wr_d    = i_req_wr;
          addr_d  = i_req_addr[NB_MEM_ADDR+1:0];
          wdata_d = i_req_wdata;
          size_d  = i_req_size;
          rdata_d = '0;
          err_d   = al_misalign;
          state_d = al_misalign ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        o_mem_cs    = 1'b1;
        o_mem_we    = wr_q;
        o_mem_be    = al_be;
        o_mem_addr  = addr_q[NB_MEM_ADDR+1:2];
        o_mem_wdata = al_wdata;
        if (wr_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = al_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        rdata_d     = '0;
        err_d       = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;

`ifdef DMEM_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q, stall_cnt_q;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (state_q == ISSUE && !wr_q && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (state_q == ISSUE && wr_q && wr_cnt_q != '1)  wr_cnt_q <= wr_cnt_q + 32'd1;
      if (i_req_valid && !o_req_ready && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_stat_rd_cnt    = rd_cnt_q;
  assign o_stat_wr_cnt    = wr_cnt_q;
  assign o_stat_stall_cnt = stall_cnt_q;
`else
  assign o_stat_rd_cnt    = '0;
  assign o_stat_wr_cnt    = '0;
  assign o_stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: two instances (latency 1 and 3), each
// in front of a behavioural SRAM, checked against a byte-level memory model.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n[2];
  logic        req_valid[2], req_wr[2];
  logic [31:0] req_addr[2], req_wdata[2];
  logic [1:0]  req_size[2];
  logic        req_ready[2], rsp_valid[2], rsp_err[2];
  logic [31:0] rsp_rdata[2];
  logic        mem_cs[2], mem_we[2];
  logic [3:0]  mem_be[2];
  logic [9:0]  mem_addr[2];
  logic [31:0] mem_wdata[2], mem_rdata[2];
  logic [31:0] stat_rd[2], stat_wr[2], stat_stall[2];

  dmem_ctrl #(.MEM_LATENCY(1)) u_dut_l1 (
    .i_clock(clk), .i_reset(rst_n[0]),
    .i_req_valid(req_valid[0]), .i_req_wr(req_wr[0]), .i_req_addr(req_addr[0]),
    .i_req_wdata(req_wdata[0]), .i_req_size(req_size[0]), .o_req_ready(req_ready[0]),
    .o_rsp_valid(rsp_valid[0]), .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0]),
    .o_mem_cs(mem_cs[0]), .o_mem_we(mem_we[0]), .o_mem_be(mem_be[0]),
    .o_mem_addr(mem_addr[0]), .o_mem_wdata(mem_wdata[0]), .i_mem_rdata(mem_rdata[0]),
    .o_stat_rd_cnt(stat_rd[0]), .o_stat_wr_cnt(stat_wr[0]), .o_stat_stall_cnt(stat_stall[0])
  );

  dmem_ctrl #(.MEM_LATENCY(3)) u_dut_l3 (
    .i_clock(clk), .i_reset(rst_n[1]),
    .i_req_valid(req_valid[1]), .i_req_wr(req_wr[1]), .i_req_addr(req_addr[1]),
    .i_req_wdata(req_wdata[1]), .i_req_size(req_size[1]), .o_req_ready(req_ready[1]),
    .o_rsp_valid(rsp_valid[1]), .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1]),
    .o_mem_cs(mem_cs[1]), .o_mem_we(mem_we[1]), .o_mem_be(mem_be[1]),
    .o_mem_addr(mem_addr[1]), .o_mem_wdata(mem_wdata[1]), .i_mem_rdata(mem_rdata[1]),
    .o_stat_rd_cnt(stat_rd[1]), .o_stat_wr_cnt(stat_wr[1]), .o_stat_stall_cnt(stat_stall[1])
  );

  // Behavioural SRAM: read data emerges LAT cycles after the select edge.
  logic [31:0] sram[2][1024];
  logic [31:0] pipe[2][4];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int k = 3; k > 0; k--) pipe[i][k] <= pipe[i][k-1];
      pipe[i][0] <= 32'hBAD0_BAD0;
      if (mem_cs[i]) begin
        if (mem_we[i]) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[i][b]) sram[i][mem_addr[i]][b*8 +: 8] <= mem_wdata[i][b*8 +: 8];
        end else begin
          pipe[i][0] <= sram[i][mem_addr[i]];
        end
      end
    end
  end
  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  int cyc = 0;
  int cs_cnt[2] = '{0, 0};
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) if (mem_cs[i]) cs_cnt[i] <= cs_cnt[i] + 1;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sbq[$];
  logic [7:0] refm[2][4096];

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (rsp_valid[i]) begin
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid[i]), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("rsp_inst",  32'(i), 32'(e.idx));
          chk("rsp_rdata", rsp_rdata[i], e.rdata);
          chk("rsp_err",   32'(rsp_err[i]), 32'(e.err));
          chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic do_req(input int idx, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size);
    int          n, nb, lat, a_cyc, cs0;
    int unsigned off;
    logic        mis;
    logic [31:0] rd;
    logic [3:0]  exp_be;
    logic [11:0] ba;
    off = 32'(addr[1:0]);
    mis = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
    nb  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    exp_be = ((nb == 1) ? 4'b0001 : (nb == 2) ? 4'b0011 : 4'b1111) << off;
    n = 0;
    while (!req_ready[idx] && n < 50) begin @(negedge clk); n++; end
    if (!req_ready[idx]) begin
      chk("ready_timeout", 32'(req_ready[idx]), 32'd1);
      return;
    end
    req_valid[idx] = 1'b1; req_wr[idx] = wr; req_addr[idx] = addr;
    req_wdata[idx] = wdata; req_size[idx] = size;
    rd = '0;
    if (mis) begin
      lat = 1;
    end else if (wr) begin
      lat = 2;
      for (int b = 0; b < nb; b++) begin
        ba = addr[11:0] + 12'(b);
        refm[idx][ba] = wdata[b*8 +: 8];
      end
    end else begin
      lat = (idx == 0 ? 1 : 3) + 2;
      for (int b = 0; b < nb; b++) begin
        ba = addr[11:0] + 12'(b);
        rd[b*8 +: 8] = refm[idx][ba];
      end
    end
    a_cyc = cyc;
    cs0   = cs_cnt[idx];
    sbq.push_back('{idx, rd, mis, a_cyc + lat});
    @(posedge clk); #1;
    req_valid[idx] = 1'b0; req_addr[idx] = $urandom; req_wdata[idx] = $urandom;
    req_size[idx] = 2'($urandom); req_wr[idx] = 1'($urandom);
    @(negedge clk);
    chk("ready_busy_a1", 32'(req_ready[idx]), 32'd0);
    if (mis) begin
      chk("mis_no_cs", 32'(mem_cs[idx]), 32'd0);
    end else begin
      chk("issue_cs",    32'(mem_cs[idx]), 32'd1);
      chk("issue_we",    32'(mem_we[idx]), 32'(wr));
      chk("issue_be",    32'(mem_be[idx]), 32'(exp_be));
      chk("issue_addr",  32'(mem_addr[idx]), 32'(addr[11:2]));
      if (wr) chk("issue_wdata", mem_wdata[idx], wdata << (8 * off));
    end
    while (cyc < a_cyc + lat) @(negedge clk);
    chk("ready_busy_resp", 32'(req_ready[idx]), 32'd0);
    @(negedge clk); #1;
    chk("rsp_done", 32'(sbq.size()), 32'd0);
    if (sbq.size() != 0) void'(sbq.pop_front());
    chk("ready_after", 32'(req_ready[idx]), 32'd1);
    chk("rdata_cleared", rsp_rdata[idx], 32'd0);
    chk("cs_pulses", 32'(cs_cnt[idx] - cs0), mis ? 32'd0 : 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_wr[i] = 1'b0;
      req_addr[i] = '0; req_wdata[i] = '0; req_size[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", 32'(req_ready[i]), 32'd1);
      chk("rst_rsp",   32'({rsp_valid[i], rsp_err[i], mem_cs[i], mem_we[i]}), 32'd0);
      chk("rst_mem",   32'(mem_be[i]) | 32'(mem_addr[i]) | mem_wdata[i] | rsp_rdata[i], 32'd0);
      rst_n[i] = 1'b1;
    end
    @(negedge clk);

    do_req(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'b10);
    do_req(0, 1'b1, 32'h0000_0013, 32'h0000_00A5, 2'b00);
    do_req(0, 1'b1, 32'h0000_0012, 32'h0000_00BE, 2'b00);
    do_req(0, 1'b0, 32'h0000_0012, 32'h0,         2'b01);
    do_req(0, 1'b0, 32'h0000_0010, 32'h0,         2'b10);
    do_req(0, 1'b0, 32'h0000_0011, 32'h0,         2'b00);
    do_req(0, 1'b0, 32'h0000_0006, 32'h0,         2'b10);
    do_req(0, 1'b0, 32'h0000_0011, 32'h0,         2'b01);
    do_req(0, 1'b1, 32'h0000_0015, 32'h1111_2222, 2'b10);
    do_req(0, 1'b0, 32'h0000_0014, 32'h0,         2'b11);
    do_req(0, 1'b1, 32'hFFFF_F018, 32'hCAFE_F00D, 2'b10);
    do_req(0, 1'b0, 32'h0000_0018, 32'h0,         2'b10);
    do_req(0, 1'b1, 32'h0000_0016, 32'h0000_7E57, 2'b01);
    do_req(0, 1'b0, 32'h0000_0016, 32'h0,         2'b01);
    do_req(0, 1'b0, 32'h0000_0017, 32'h0,         2'b00);

    do_req(1, 1'b1, 32'h0000_0020, 32'h1234_5678, 2'b10);
    do_req(1, 1'b0, 32'h0000_0020, 32'h0,         2'b10);
    do_req(1, 1'b0, 32'h0000_0022, 32'h0,         2'b01);

    // Abort a latency-3 load in WAIT with an asynchronous reset.
    req_valid[1] = 1'b1; req_wr[1] = 1'b0; req_addr[1] = 32'h20; req_size[1] = 2'b10;
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n[1] = 1'b0;
    #1;
    chk("arst_cs",    32'(mem_cs[1]), 32'd0);
    chk("arst_rsp",   32'(rsp_valid[1]), 32'd0);
    chk("arst_ready", 32'(req_ready[1]), 32'd1);
    chk("arst_rdata", rsp_rdata[1], 32'd0);
    repeat (2) @(negedge clk);
    chk("arst_stats", stat_rd[1] | stat_wr[1] | stat_stall[1], 32'd0);
    rst_n[1] = 1'b1;
    @(negedge clk);
    chk("arst_ready_rel", 32'(req_ready[1]), 32'd1);
    do_req(1, 1'b0, 32'h0000_0020, 32'h0, 2'b10);
    do_req(1, 1'b0, 32'h0000_0021, 32'h0, 2'b10);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
